rv_dmem_ctrl: RTL and testbench
===============================

RV_DMEM_CTRL -- requirements
Module: rv_dmem_ctrl

Interface
REQ-001 The parameter PRIO_FIXED SHALL default to 0; 0 = round-robin between ports, 1 = port 0 always wins.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pN_req_valid  input  1  request from port N, N in {0,1} (0 = LSU, 1 = DMA).
REQ-005 pN_req_ready  output  1  controller accepts port N request this cycle.
REQ-006 pN_req_addr  input  32  byte address; bits [2:0] ignored.
REQ-007 pN_req_we  input  1  1 = store, 0 = load.
REQ-008 pN_req_wdata  input  64  store data.
REQ-009 pN_req_wstrb  input  8  byte enables for the store; bit i covers wdata[8i+7:8i].
REQ-010 pN_resp_valid  output  1  one-cycle completion pulse for port N; no backpressure.
REQ-011 pN_resp_rdata  output  64  load data, valid with pN_resp_valid; 0 for stores.
REQ-012 mem_addr  output  32  to data memory; always {addr[31:3],3'b000}.
REQ-013 mem_wr_en / mem_wr_data  output  1 / 64  memory write strobe and data.
REQ-014 mem_rd_en  output  1  memory read strobe.
REQ-015 mem_rd_data  input  64  memory read data, combinationally valid in the same cycle as mem_rd_en.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, MERGE_WR, RESP.
REQ-017 In IDLE, pN_req_ready SHALL be 1 only for the arbitration winner among asserted pN_req_valid; both readies SHALL be 0 in all other states.
REQ-018 Round-robin (PRIO_FIXED=0) SHALL grant the port not granted last when both are valid; a lone valid port SHALL win immediately.
REQ-019 A handshake (valid && ready) in IDLE SHALL latch port id, addr, we, wdata, and wstrb, and move to ACCESS.
REQ-020 ACCESS, load: mem_rd_en=1, capture mem_rd_data, go to RESP.
REQ-021 ACCESS, store with wstrb=8'hFF: mem_wr_en=1, mem_wr_data=wdata, go to RESP.
REQ-022 ACCESS, store with partial nonzero wstrb: mem_rd_en=1, register the merge (strobed bytes from wdata, others from mem_rd_data), go to MERGE_WR.
REQ-023 MERGE_WR: mem_wr_en=1 with the merged data, go to RESP.
REQ-024 ACCESS, store with wstrb=0: no memory strobe, go to RESP.
REQ-025 RESP: assert pN_resp_valid for the latched port for exactly one cycle, then return to IDLE.
REQ-026 Latency from handshake edge T SHALL be: load/full store/zero-strobe store resp at T+2; partial store resp at T+3.
REQ-027 mem_rd_en and mem_wr_en SHALL never be 1 together, and SHALL be 0 in IDLE and RESP.
REQ-028 mem_addr and mem_wr_data SHALL be 0 when no strobe is asserted.
REQ-029 pN_resp_rdata SHALL hold its last value except when a new response is produced.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, all outputs 0, and the round-robin pointer to "port 1 last granted" so port 0 wins first.
REQ-031 Reset mid-operation SHALL abandon the in-flight request with no response and no further memory strobe; a MERGE_WR write not yet clocked is dropped.

Configuration
REQ-032 Macro RV_DMEM_RMW_EN defined: byte-strobe read-modify-write per REQ-022/023 is enabled.
REQ-033 Macro RV_DMEM_RMW_EN undefined: wstrb SHALL be ignored, every store SHALL be a full 64-bit write per REQ-021, and MERGE_WR SHALL be absent.

Verification
REQ-034 p0 load addr 0x10, memory holds 64'h1122334455667788 -> p0_resp_valid at T+2, rdata 64'h1122334455667788, p1 silent.
REQ-035 Both ports valid in IDLE three times, PRIO_FIXED=0 -> grants p0, p1, p0; PRIO_FIXED=1 -> p0, p0, p0.
REQ-036 RMW_EN, memory 0x0 holds 64'hFFFFFFFFFFFFFFFF, p1 store wdata 0, wstrb 8'h0F -> one read, one write 64'hFFFFFFFF00000000, resp at T+3.
REQ-037 Without RMW_EN, same stimulus as REQ-036 -> single write of 64'h0, resp at T+2.
REQ-038 rst_n low during MERGE_WR -> no mem_wr_en, no resp_valid; after release, p0 wins the first contended grant.
REQ-039 p0 store addr 0x1F, wstrb 0 -> no memory strobes, mem_addr 0 throughout, resp at T+2.

Source files
------------

// File: rtl/rv_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// rv_dmem_ctrl
// Two-port data-memory controller. Port 0 (LSU) and port 1 (DMA) share one
// 64-bit data memory. A single request is in flight at a time. Accepted
// requests go through IDLE -> ACCESS -> (MERGE_WR) -> RESP.
//
// Parameters
//   PRIO_FIXED  0: round-robin between ports, 1: port 0 always wins
//
// Build option
//   RV_DMEM_RMW_EN  when defined, partial-strobe stores become a
//                   read-modify-write (read in ACCESS, write in MERGE_WR).
//                   When undefined, wstrb is ignored and every store is a
//                   full 64-bit write.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   pN_req_valid/ready           request handshake, N in {0,1}
//   pN_req_addr/we/wdata/wstrb   request payload (addr[2:0] ignored)
//   pN_resp_valid/rdata          one-cycle completion pulse and load data
//   mem_addr                     doubleword-aligned address, 0 when idle
//   mem_wr_en/mem_wr_data        memory write strobe and data
//   mem_rd_en/mem_rd_data        memory read strobe, same-cycle read data
// ---------------------------------------------------------------------------
module rv_dmem_ctrl #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_req_addr,
  input  logic        p0_req_we,
  input  logic [63:0] p0_req_wdata,
  input  logic [7:0]  p0_req_wstrb,
  output logic        p0_resp_valid,
  output logic [63:0] p0_resp_rdata,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_req_addr,
  input  logic        p1_req_we,
  input  logic [63:0] p1_req_wdata,
  input  logic [7:0]  p1_req_wstrb,
  output logic        p1_resp_valid,
  output logic [63:0] p1_resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_data,
  output logic        mem_rd_en,
  input  logic [63:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
`ifdef RV_DMEM_RMW_EN
    MERGE_WR = 2'd2,
`endif
    RESP     = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        last_grant_reg;   // 1 = port 1 was granted last
  logic        port_reg;
  logic [28:0] addr_reg;
  logic        we_reg;
  logic [63:0] wdata_reg;
  logic [63:0] rdata0_reg, rdata1_reg;
  logic        grant0, grant1, hs;
  logic        st_full, st_partial;

`ifdef RV_DMEM_RMW_EN
  logic [7:0]  wstrb_reg;
  logic [63:0] merge_reg, merge_next;

  // Strobed bytes come from the store data, the rest from current memory.
  for (genvar gi = 0; gi < 8; gi++) begin : g_merge
    assign merge_next[8*gi +: 8] = wstrb_reg[gi] ? wdata_reg[8*gi +: 8]
                                                 : mem_rd_data[8*gi +: 8];
  end

  assign st_full    = we_reg && (wstrb_reg == 8'hFF);
  assign st_partial = we_reg && (wstrb_reg != 8'h00) && (wstrb_reg != 8'hFF);
  logic unused_bits;
  assign unused_bits = ^{p0_req_addr[2:0], p1_req_addr[2:0]};
`else
  assign st_full    = we_reg;
  assign st_partial = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{p0_req_addr[2:0], p1_req_addr[2:0],
                         p0_req_wstrb, p1_req_wstrb};
`endif

  // Arbitration: port 0 wins when fixed priority, when alone, or when port 1
  // was granted last.
  assign grant0 = p0_req_valid && (PRIO_FIXED || !p1_req_valid || last_grant_reg);
  assign grant1 = p1_req_valid && !grant0;

  // Readies are gated by rst_n so they drop the moment reset asserts.
  assign p0_req_ready = rst_n && (state_reg == IDLE) && grant0;
  assign p1_req_ready = rst_n && (state_reg == IDLE) && grant1;
  assign hs           = p0_req_ready || p1_req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (hs) state_next = ACCESS;
      ACCESS:   state_next = RESP;
`ifdef RV_DMEM_RMW_EN
      MERGE_WR: state_next = RESP;
`endif
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
`ifdef RV_DMEM_RMW_EN
    if (state_reg == ACCESS && st_partial) state_next = MERGE_WR;
`endif
  end

  // Output logic
  always_comb begin
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    mem_wr_data   = 64'h0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    case (state_reg)
      ACCESS: begin
        mem_rd_en = !we_reg || st_partial;
        if (st_full) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = wdata_reg;
        end
      end
`ifdef RV_DMEM_RMW_EN
      MERGE_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_data = merge_reg;
      end
`endif
      RESP: begin
        p0_resp_valid = !port_reg;
        p1_resp_valid = port_reg;
      end
      default: ;
    endcase
    mem_addr = (mem_rd_en || mem_wr_en) ? {addr_reg, 3'b000} : 32'h0;
  end

  assign p0_resp_rdata = rdata0_reg;
  assign p1_resp_rdata = rdata1_reg;

  // Request latch, arbitration pointer and response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      port_reg       <= 1'b0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
`ifdef RV_DMEM_RMW_EN
      wstrb_reg      <= '0;
      merge_reg      <= '0;
`endif
    end else begin
      if (hs) begin
        last_grant_reg <= p1_req_ready;
        port_reg       <= p1_req_ready;
        addr_reg       <= p1_req_ready ? p1_req_addr[31:3] : p0_req_addr[31:3];
        we_reg         <= p1_req_ready ? p1_req_we         : p0_req_we;
        wdata_reg      <= p1_req_ready ? p1_req_wdata      : p0_req_wdata;
`ifdef RV_DMEM_RMW_EN
        wstrb_reg      <= p1_req_ready ? p1_req_wstrb      : p0_req_wstrb;
`endif
      end
`ifdef RV_DMEM_RMW_EN
      if (state_reg == ACCESS && st_partial) merge_reg <= merge_next;
`endif
      // Response data changes only on the edge that enters RESP.
      if (state_next == RESP && state_reg != RESP) begin
        if (!port_reg) rdata0_reg <= we_reg ? 64'h0 : mem_rd_data;
        else           rdata1_reg <= we_reg ? 64'h0 : mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_dmem_ctrl
// Directed bench for rv_dmem_ctrl. dut drives a small doubleword memory
// model; dut_fix (PRIO_FIXED=1) shares the request inputs and is only
// observed for its arbitration choices. Expectations depend on whether
// RV_DMEM_RMW_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_rv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req_valid = 0, p1_req_valid = 0;
  logic [31:0] p0_req_addr = 0, p1_req_addr = 0;
  logic        p0_req_we = 0, p1_req_we = 0;
  logic [63:0] p0_req_wdata = 0, p1_req_wdata = 0;
  logic [7:0]  p0_req_wstrb = 0, p1_req_wstrb = 0;
  logic        p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid;
  logic [63:0] p0_resp_rdata, p1_resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr_en, mem_rd_en;
  logic [63:0] mem_wr_data, mem_rd_data;

  logic        f_p0_req_ready, f_p1_req_ready, f_p0_resp_valid, f_p1_resp_valid;
  logic [63:0] f_p0_resp_rdata, f_p1_resp_rdata, f_mem_wr_data;
  logic [31:0] f_mem_addr;
  logic        f_mem_wr_en, f_mem_rd_en;

  logic [63:0] mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;
  int          viol = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  rv_dmem_ctrl #(.PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_we(p0_req_we),
    .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_we(p1_req_we),
    .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
  );

  rv_dmem_ctrl #(.PRIO_FIXED(1'b1)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(f_p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_we(p0_req_we),
    .p0_req_wdata(p0_req_wdata), .p0_req_wstrb(p0_req_wstrb),
    .p0_resp_valid(f_p0_resp_valid), .p0_resp_rdata(f_p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(f_p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_we(p1_req_we),
    .p1_req_wdata(p1_req_wdata), .p1_req_wstrb(p1_req_wstrb),
    .p1_resp_valid(f_p1_resp_valid), .p1_resp_rdata(f_p1_resp_rdata),
    .mem_addr(f_mem_addr), .mem_wr_en(f_mem_wr_en), .mem_wr_data(f_mem_wr_data),
    .mem_rd_en(f_mem_rd_en), .mem_rd_data(64'h0)
  );

  // Memory model: combinational read, write on the rising edge.
  assign mem_rd_data = mem[mem_addr[7:3]];
  always @(posedge clk) begin
    if (pl_en)          mem[pl_idx] <= pl_data;
    else if (mem_wr_en) mem[mem_addr[7:3]] <= mem_wr_data;
  end

  // Strobe exclusivity and idle-bus-zero watch over the whole run.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en && mem_wr_en) viol <= viol + 1;
      if (!mem_rd_en && !mem_wr_en && (mem_addr != 32'h0 || mem_wr_data != 64'h0))
        viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [63:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request on one port; returns latency (edges after handshake edge at
  // which the response is captured), strobe counts, last write, other-port
  // response count.
  task automatic xact(input int port, input logic [31:0] addr, input logic we,
                      input logic [63:0] wd, input logic [7:0] ws,
                      output int lat, output int nrd, output int nwr,
                      output logic [63:0] wdat, output logic [31:0] wadr,
                      output int other);
    bit got;
    lat = 0; nrd = 0; nwr = 0; wdat = '0; wadr = '0; other = 0; got = 0;
    if (port == 0) begin
      p0_req_addr = addr; p0_req_we = we; p0_req_wdata = wd; p0_req_wstrb = ws;
      p0_req_valid = 1'b1;
    end else begin
      p1_req_addr = addr; p1_req_we = we; p1_req_wdata = wd; p1_req_wstrb = ws;
      p1_req_valid = 1'b1;
    end
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if ((port == 0) ? p0_req_ready : p1_req_ready) got = 1;
    end
    if (!got) begin
      check("handshake_timeout", 64'd0, 64'd1);
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (mem_rd_en) nrd++;
      if (mem_wr_en) begin nwr++; wdat = mem_wr_data; wadr = mem_addr; end
      if ((port == 0) ? p1_resp_valid : p0_resp_valid) other++;
      if ((port == 0) ? p0_resp_valid : p1_resp_valid) lat = n;
    end
    @(posedge clk); #1;
  endtask

  // Both ports request a load; returns {p1_ready,p0_ready} of each DUT.
  task automatic contend(output logic [1:0] g_rr, output logic [1:0] g_fix);
    p0_req_addr = 32'h10; p0_req_we = 1'b0;
    p1_req_addr = 32'h18; p1_req_we = 1'b0;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    @(negedge clk);
    g_rr  = {p1_req_ready, p0_req_ready};
    g_fix = {f_p1_req_ready, f_p0_req_ready};
    @(posedge clk); #1;
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  int          lat, nrd, nwr, oth, rst_resp, rst_wr;
  logic [63:0] wdat;
  logic [31:0] wadr;
  logic [1:0]  g_rr, g_fix;
  logic [1:0]  exp_rr [3];

  initial begin
    exp_rr = '{2'b01, 2'b10, 2'b01};

    // Reset: outputs held low even with a request pending.
    p0_req_valid = 1'b1;
    @(negedge clk);
    check("rst_ready", {62'd0, p1_req_ready, p0_req_ready}, 64'd0);
    check("rst_strobes", {62'd0, mem_rd_en, mem_wr_en}, 64'd0);
    check("rst_resp", {62'd0, p1_resp_valid, p0_resp_valid}, 64'd0);
    check("rst_rdata", p0_resp_rdata | p1_resp_rdata, 64'd0);
    p0_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration, three contended rounds.
    for (int i = 0; i < 3; i++) begin
      contend(g_rr, g_fix);
      check($sformatf("arb_rr_%0d", i), {62'd0, g_rr}, {62'd0, exp_rr[i]});
      check($sformatf("arb_fix_%0d", i), {62'd0, g_fix}, 64'd1);
    end

    // p0 load from 0x10.
    preload(5'd2, 64'h1122334455667788);
    xact(0, 32'h10, 1'b0, 64'h0, 8'h00, lat, nrd, nwr, wdat, wadr, oth);
    check("load_lat", lat, 2);
    check("load_rdata", p0_resp_rdata, 64'h1122334455667788);
    check("load_p1_silent", oth, 0);
    check("load_nrd", nrd, 1);
    check("load_nwr", nwr, 0);

    // p1 partial store, wstrb 0x0F, over all-ones.
    preload(5'd0, 64'hFFFFFFFFFFFFFFFF);
    xact(1, 32'h0, 1'b1, 64'h0, 8'h0F, lat, nrd, nwr, wdat, wadr, oth);
`ifdef RV_DMEM_RMW_EN
    check("pstore_lat", lat, 3);
    check("pstore_nrd", nrd, 1);
    check("pstore_wdata", wdat, 64'hFFFFFFFF00000000);
    check("pstore_mem", mem[0], 64'hFFFFFFFF00000000);
`else
    check("pstore_lat", lat, 2);
    check("pstore_nrd", nrd, 0);
    check("pstore_wdata", wdat, 64'h0);
    check("pstore_mem", mem[0], 64'h0);
`endif
    check("pstore_nwr", nwr, 1);
    check("pstore_rdata", p1_resp_rdata, 64'h0);
    check("p0_rdata_hold", p0_resp_rdata, 64'h1122334455667788);

    // p0 zero-strobe store at unaligned 0x1F.
    xact(0, 32'h1F, 1'b1, 64'hDEADBEEFCAFEF00D, 8'h00, lat, nrd, nwr, wdat, wadr, oth);
    check("zstore_lat", lat, 2);
    check("zstore_nrd", nrd, 0);
`ifdef RV_DMEM_RMW_EN
    check("zstore_nwr", nwr, 0);
`else
    check("zstore_nwr", nwr, 1);
    check("zstore_wadr", wadr, 32'h18);
`endif

    // p0 full store at unaligned 0x2D, then load it back.
    xact(0, 32'h2D, 1'b1, 64'hA5A5_0123_4567_89AB, 8'hFF, lat, nrd, nwr, wdat, wadr, oth);
    check("fstore_lat", lat, 2);
    check("fstore_nrd", nrd, 0);
    check("fstore_wadr", wadr, 32'h28);
    check("fstore_wdata", wdat, 64'hA5A5_0123_4567_89AB);
    xact(0, 32'h28, 1'b0, 64'h0, 8'h00, lat, nrd, nwr, wdat, wadr, oth);
    check("readback_rdata", p0_resp_rdata, 64'hA5A5_0123_4567_89AB);

    // Reset in the middle of a store (MERGE_WR when RMW, else ACCESS).
    preload(5'd1, 64'h0123456789ABCDEF);
    p0_req_addr = 32'h8; p0_req_we = 1'b1; p0_req_wdata = 64'h0; p0_req_wstrb = 8'h0F;
    p0_req_valid = 1'b1;
    @(negedge clk);
    check("mid_ready", {63'd0, p0_req_ready}, 64'd1);
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    @(negedge clk);
`ifdef RV_DMEM_RMW_EN
    @(negedge clk);
`endif
    check("mid_wr_pending", {63'd0, mem_wr_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wr_dropped", {63'd0, mem_wr_en}, 64'd0);
    rst_resp = 0; rst_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (p0_resp_valid || p1_resp_valid) rst_resp++;
      if (mem_wr_en || mem_rd_en) rst_wr++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (p0_resp_valid || p1_resp_valid) rst_resp++;
      if (mem_wr_en || mem_rd_en) rst_wr++;
    end
    check("mid_no_resp", rst_resp, 0);
    check("mid_no_strobe", rst_wr, 0);
    check("mid_mem_intact", mem[1], 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    contend(g_rr, g_fix);
    check("post_rst_arb", {62'd0, g_rr}, 64'd1);

    check("bus_rules", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Overall time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
